i2s_rx_capture: RTL and testbench
=================================

I2S_RX_CAPTURE -- requirements
Module: i2s_rx_capture

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits (8..32).
REQ-002 clk  input  1  system clock; all logic in this domain; frequency at least 4x sclk.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 sclk  input  1  I2S bit clock, asynchronous to clk.
REQ-005 lrclk  input  1  I2S word select, asynchronous to clk; 0 = left, 1 = right.
REQ-006 i2s  input  1  I2S serial data, MSB first, sampled on sclk rising edge.
REQ-007 out_left  output  DATA_W  captured left sample.
REQ-008 out_right  output  DATA_W  captured right sample.
REQ-009 out_valid  output  1  stereo pair available.
REQ-010 out_ready  input  1  consumer accepts the pair when high with out_valid.
REQ-011 ovf_clr  input  1  clears the overflow flag.
REQ-012 overflow  output  1  sticky flag: a completed pair was dropped.

Function
REQ-013 sclk, lrclk and i2s SHALL each pass through a 2-flop synchronizer; the synchronizer flops reset to 0.
REQ-014 A bit event SHALL be a one-clk pulse on synchronized sclk 0->1; the synchronized lrclk and i2s values SHALL be sampled only on bit events.
REQ-015 A boundary SHALL be a bit event whose sampled lrclk differs from the lrclk sampled at the previous bit event.
REQ-016 At a boundary: the word being assembled completes, bit_cnt clears to 0, and the shift register clears; the data bit at the boundary event itself belongs to the previous word's LSB position (I2S one-bit delay).
REQ-017 At each non-boundary bit event with bit_cnt < DATA_W, the data bit SHALL be written to position DATA_W-1-bit_cnt and bit_cnt SHALL increment; bits beyond DATA_W are ignored and bit_cnt saturates at DATA_W.
REQ-018 A short word (fewer than DATA_W bits) SHALL be left-aligned with zero LSBs.
REQ-019 The word completing on an lrclk 0->1 boundary SHALL be held as the left sample; the word completing on a 1->0 boundary completes the pair with the right sample.
REQ-020 After reset, words SHALL be discarded until the first boundary has been seen; the first reported pair SHALL be a left word and a right word that are both complete.
REQ-021 Pair completion SHALL load out_left/out_right and set out_valid in the clk cycle after the completing bit event.
REQ-022 A transfer occurs when out_valid && out_ready; on a transfer without a simultaneous completion, out_valid SHALL clear on the next clk.
REQ-023 If completion and transfer coincide, the new pair SHALL load, out_valid SHALL stay 1, and overflow SHALL NOT set.
REQ-024 If a completion occurs while out_valid=1 and out_ready=0, the held pair SHALL be kept, the new pair dropped, and overflow SHALL set.
REQ-025 ovf_clr SHALL clear overflow next cycle; a simultaneous new overflow event SHALL win (overflow stays 1).
REQ-026 out_left and out_right SHALL remain stable while out_valid=1 and no transfer occurs.

Reset
REQ-027 On reset_n low: out_left=0, out_right=0, out_valid=0, overflow=0, bit_cnt=0, shift register=0, the sync flag cleared, and the previous-lrclk register=0.
REQ-028 Reset mid-word SHALL discard all partial data; capture SHALL resume per REQ-020.

Structure
REQ-029 Package i2s_rx_pkg SHALL hold the channel constants (CH_LEFT=0, CH_RIGHT=1) and the bit-counter width function clog2(DATA_W+1).
REQ-030 The synchronizer SHALL be a sub-module i2s_sync2 (2 flops, asynchronous active-low reset), instantiated three times.

Verification
REQ-031 Bench settings: DATA_W=16, clk 50 MHz, sclk 3.072 MHz, 32-bit slots. Send L=0xA55A, R=0x1234 with out_ready=1 -> out_left=0xA55A, out_right=0x1234, out_valid high for 1 clk.
REQ-032 Hold out_ready=0 and send pairs (0x1111,0x2222) then (0x3333,0x4444) -> outputs stay at 0x1111/0x2222 and overflow=1; pulse ovf_clr -> overflow=0.
REQ-033 Send 8-bit words L=0xAB, R=0xCD -> out_left=0xAB00, out_right=0xCD00.
REQ-034 Release reset in the middle of a left word, then send (0x0F0F,0xF0F0) -> no pair is reported for the partial frame; the first pair reported is 0x0F0F/0xF0F0.
REQ-035 Assert out_ready in the exact cycle a new pair (0x5555,0xAAAA) completes while the previous pair is valid -> new pair loaded, out_valid stays 1, overflow=0.
REQ-036 Send 32-bit words L=0x89ABCDEF -> out_left=0x89AB (extra bits ignored).

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared constants for the I2S receive capture block: channel encoding of
// the word-select line and the bit-counter width helper.
package i2s_rx_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Counter must be able to hold the value data_w itself (saturation point).
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/i2s_sync2.sv
// Two-flop synchronizer bringing one asynchronous I2S line into the clk domain.
module i2s_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S receiver: oversamples sclk/lrclk/data in the clk domain, assembles
// MSB-first words and presents left/right pairs on a valid/ready output.
module i2s_rx_capture
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              i2s,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic              overflow
);

  localparam int               CNT_W   = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  logic              sclk_s;
  logic              lr_s;
  logic              dat_s;
  logic              sclk_d;
  logic              prev_lr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] left_hold;
  logic              synced;
  logic              have_left;
  logic              bit_ev;
  logic              boundary;
  logic              pair_done;
  logic              xfer;
  logic              ovf_event;

  i2s_sync2 u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(sclk),  .q(sclk_s));
  i2s_sync2 u_sync_lr   (.clk(clk), .reset_n(reset_n), .d(lrclk), .q(lr_s));
  i2s_sync2 u_sync_dat  (.clk(clk), .reset_n(reset_n), .d(i2s),   .q(dat_s));

  always_comb begin
    bit_ev   = sclk_s & ~sclk_d;
    boundary = bit_ev && (lr_s != prev_lr);
    // Current bit placed at its MSB-first slot; no slot matches once saturated.
    shift_in = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(bit_cnt) == DATA_W - 1 - i) shift_in[i] = dat_s;
    end
    pair_done = boundary && (lr_s == CH_LEFT) && synced && have_left;
    xfer      = out_valid && out_ready;
    ovf_event = pair_done && out_valid && !out_ready;
  end

  // Word assembly. The bit arriving on a boundary still belongs to the word
  // that is ending (one-bit I2S delay), hence shift_in is what completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d    <= 1'b0;
      prev_lr   <= 1'b0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      left_hold <= '0;
      synced    <= 1'b0;
      have_left <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      if (bit_ev) begin
        prev_lr <= lr_s;
        if (boundary) begin
          bit_cnt <= '0;
          shift_q <= '0;
          synced  <= 1'b1;
          if (lr_s == CH_RIGHT) begin
            left_hold <= shift_in;
            have_left <= synced;
          end else begin
            have_left <= 1'b0;
          end
        end else if (bit_cnt < CNT_MAX) begin
          shift_q <= shift_in;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Handshake: a pair transfers on any clk where out_valid && out_ready.
  // While out_valid is high without a transfer the pair is frozen; a new
  // pair arriving then is dropped and flagged in the sticky overflow bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pair_done && (!out_valid || out_ready)) begin
        out_left  <= left_hold;
        out_right <= shift_in;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: an I2S transmitter model feeds 32-bit slots,
// expected pairs are queued at send time and a monitor checks each transfer.
`timescale 1ns/1ps
module tb_i2s_rx_capture;

  localparam int      DW   = 16;
  localparam realtime HALF = 162.76;

  logic          clk;
  logic          reset_n;
  logic          sclk;
  logic          lrclk;
  logic          i2s;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_right;
  logic          out_valid;
  logic          out_ready;
  logic          ovf_clr;
  logic          overflow;

  logic [2*DW-1:0] exp_q[$];
  int              n_tests;
  int              n_fail;
  logic            pending;
  logic            left_open;
  logic            rand_run;
  logic            prev_hold;
  logic [DW-1:0]   prev_l;
  logic [DW-1:0]   prev_r;

  i2s_rx_capture #(.DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .lrclk(lrclk), .i2s(i2s),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a word in a 32-bit slot is sent MSB first and the receiver
  // keeps the first DW bits of the slot.
  function automatic logic [DW-1:0] exp_word(input logic [31:0] w, input int width);
    logic [31:0] s;
    s = w << (32 - width);
    return s[31 -: DW];
  endfunction

  // driver tasks
  task automatic tx_bit(input logic lr, input logic d);
    sclk  = 1'b0;
    lrclk = lr;
    i2s   = d;
    #(HALF);
    @(negedge clk);
    sclk = 1'b1;
    #(HALF);
  endtask

  task automatic tx_slot(input logic ch, input logic [31:0] s);
    for (int k = 0; k < 32; k++) begin
      if (k == 0 && ch == 1'b0 && left_open) left_open = 1'b0;
      else tx_bit(ch, (k == 0) ? pending : s[32-k]);
    end
    pending = s[0];
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int width);
    tx_slot(1'b0, l << (32 - width));
    tx_slot(1'b1, r << (32 - width));
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r, input int width);
    exp_q.push_back({exp_word(l, width), exp_word(r, width)});
  endtask

  task automatic flush();
    tx_bit(1'b0, pending);
    left_open = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic valid_pulse_check();
    int t;
    t = 0;
    while (!out_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("valid_seen", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("valid_one_clk", 32'(out_valid), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (reset_n && prev_hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_left", 32'(out_left), 32'(prev_l));
      check("hold_right", 32'(out_right), 32'(prev_r));
    end
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", 32'(out_left), 32'(e[2*DW-1:DW]));
        check("pair_right", 32'(out_right), 32'(e[DW-1:0]));
      end
    end
    prev_hold = reset_n && out_valid && !out_ready;
    prev_l    = out_left;
    prev_r    = out_right;
  end

  initial begin
    logic [31:0] l;
    logic [31:0] r;
    int          w;
    n_tests   = 0;
    n_fail    = 0;
    pending   = 1'b0;
    left_open = 1'b0;
    rand_run  = 1'b0;
    prev_hold = 1'b0;
    reset_n   = 1'b0;
    sclk      = 1'b0;
    lrclk     = 1'b0;
    i2s       = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    repeat (5) @(negedge clk);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // First frame after reset only establishes word alignment.
    send_pair($urandom, $urandom, 16);

    // Basic pair, consumer always ready.
    set_ready(1'b1);
    push_pair(32'hA55A, 32'h1234, 16);
    send_pair(32'hA55A, 32'h1234, 16);
    fork
      flush();
      valid_pulse_check();
    join
    drain();

    // Short words are left-aligned.
    push_pair(32'hAB, 32'hCD, 8);
    send_pair(32'hAB, 32'hCD, 8);
    flush();
    drain();

    // Long words are truncated to the first DW bits.
    r = $urandom;
    push_pair(32'h89ABCDEF, r, 32);
    send_pair(32'h89ABCDEF, r, 32);
    flush();
    drain();

    // Overflow: second pair dropped while the first is held.
    set_ready(1'b0);
    push_pair(32'h1111, 32'h2222, 16);
    send_pair(32'h1111, 32'h2222, 16);
    send_pair(32'h3333, 32'h4444, 16);
    flush();
    repeat (4) @(negedge clk);
    check("ovf_hold_left", 32'(out_left), 32'h1111);
    check("ovf_hold_right", 32'(out_right), 32'h2222);
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    check("ovf_set", 32'(overflow), 32'd1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Transfer coincides with completion of the next pair.
    push_pair(32'h5555, 32'hAAAA, 16);
    send_pair(32'h5555, 32'hAAAA, 16);
    sclk  = 1'b0;
    lrclk = 1'b0;
    i2s   = pending;
    #(HALF);
    @(negedge clk);
    sclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    left_open = 1'b1;
    @(negedge clk);
    check("coincide_valid", 32'(out_valid), 32'd1);
    check("coincide_left", 32'(out_left), 32'h5555);
    check("coincide_right", 32'(out_right), 32'hAAAA);
    check("coincide_no_ovf", 32'(overflow), 32'd0);
    repeat (8) @(posedge clk);
    set_ready(1'b1);
    drain();

    // Random words and widths with a randomly stalling consumer.
    rand_run = 1'b1;
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          case ($urandom_range(0, 3))
            0:       w = 8;
            1:       w = 16;
            2:       w = 24;
            default: w = 32;
          endcase
          l = $urandom;
          r = $urandom;
          push_pair(l, r, w);
          send_pair(l, r, w);
        end
        flush();
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    set_ready(1'b1);
    drain();
    check("rand_no_ovf", 32'(overflow), 32'd0);

    // Reset released in the middle of a left word.
    @(posedge clk);
    #1 reset_n = 1'b0;
    left_open = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 12) begin
        @(posedge clk);
        #1 reset_n = 1'b1;
      end
      tx_bit(1'b0, 1'($urandom_range(0, 1)));
    end
    tx_slot(1'b1, $urandom);
    push_pair(32'h0F0F, 32'hF0F0, 16);
    send_pair(32'h0F0F, 32'hF0F0, 16);
    flush();
    drain();
    check("final_no_ovf", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
